// File: rtl/vga_timing_pipe.sv
// VGA raster generator with a request/return colour pipeline: pixel coordinates
// go out to the colour logic, and sync/de/RGB come back delayed to stay aligned.
module vga_timing_pipe #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CLK_DIV   = 4,
    parameter int PIPE      = 2,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] req_x,
    output logic [CNT_W-1:0] req_y,
    output logic             req_valid,
    output logic             pix_tick,
    output logic             frame_start,
    output logic             line_start,
    input  logic [11:0]      rgb_in,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SY_LO = H_ACTIVE + H_FP;
    localparam int H_SY_HI = H_SY_LO + H_SYNC;
    localparam int V_SY_LO = V_ACTIVE + V_FP;
    localparam int V_SY_HI = V_SY_LO + V_SYNC;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [CNT_W-1:0] h_cnt_reg;
    logic [CNT_W-1:0] v_cnt_reg;
    logic             h_last;
    logic             v_last;
    logic             h_vis;
    logic             v_vis;
    logic             h_sy;
    logic             v_sy;
    logic [2:0]       stage_in [PIPE];
    logic [2:0]       dly_reg  [PIPE];
    logic             hsy_next;
    logic             vsy_next;
    logic             de_next;

    // With CLK_DIV=1 the counter is pinned at 0 and every clk is a pixel tick.
    assign pix_tick = (div_cnt_reg == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
        end else if (pix_tick) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    assign h_last = (h_cnt_reg == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_cnt_reg == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (pix_tick) begin
            h_cnt_reg <= h_last ? '0 : h_cnt_reg + 1'b1;
            if (h_last) begin
                v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        h_vis = (h_cnt_reg < CNT_W'(H_ACTIVE));
        v_vis = (v_cnt_reg < CNT_W'(V_ACTIVE));
        h_sy  = (h_cnt_reg >= CNT_W'(H_SY_LO)) && (h_cnt_reg < CNT_W'(H_SY_HI));
        v_sy  = (v_cnt_reg >= CNT_W'(V_SY_LO)) && (v_cnt_reg < CNT_W'(V_SY_HI));
    end

    assign req_x       = h_cnt_reg;
    assign req_y       = v_cnt_reg;
    assign req_valid   = h_vis & v_vis;
    assign line_start  = pix_tick & (h_cnt_reg == '0);
    assign frame_start = line_start & (v_cnt_reg == '0);

    // Stage 0 takes the live decode; each later stage takes its predecessor.
    generate
        for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_in[gi] = {h_sy, v_sy, req_valid};
            end else begin : g_body
                assign stage_in[gi] = dly_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                dly_reg[i] <= '0;
            end
        end else if (pix_tick) begin
            for (int i = 0; i < PIPE; i++) begin
                dly_reg[i] <= stage_in[i];
            end
        end
    end

    assign {hsy_next, vsy_next, de_next} = dly_reg[PIPE-1];

    // Colour is gated by the delayed valid so blanking is black whatever rgb_in holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= ~HS_ON;
            vsync <= ~VS_ON;
            de    <= 1'b0;
            red   <= 4'h0;
            green <= 4'h0;
            blue  <= 4'h0;
        end else if (pix_tick) begin
            hsync <= hsy_next ? HS_ON : ~HS_ON;
            vsync <= vsy_next ? VS_ON : ~VS_ON;
            de    <= de_next;
            {red, green, blue} <= de_next ? rgb_in : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: three small-geometry instances checked every cycle
// against an edge-count model, plus probe tables and multi-cycle sequences.
module tb_vga_timing_pipe;

    localparam int CW = 11;
    // Instance A: active-low syncs, CLK_DIV=3, PIPE=2, 15x8 raster.
    localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VA = 4, A_VF = 1, A_VS = 2, A_VB = 1;
    localparam int A_D = 3, A_P = 2;
    localparam int A_HT = 15, A_VT = 8;
    // Instance B: active-high syncs, CLK_DIV=1, PIPE=8, 14x7 raster, white input.
    localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
    localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_D = 1, B_P = 8;
    // Instance C: same raster as B, active-low, CLK_DIV=2, PIPE=1.
    localparam int C_D = 2, C_P = 1;

    typedef struct {
        int         x;
        int         y;
        logic       hs;
        logic       vs;
        logic       de;
        logic [11:0] rgb;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ecnt;
    int   checks = 0;
    int   errors = 0;

    logic [CW-1:0] req_x_a, req_y_a, req_x_b, req_y_b, req_x_c, req_y_c;
    logic req_valid_a, pix_tick_a, frame_start_a, line_start_a, hsync_a, vsync_a, de_a;
    logic req_valid_b, pix_tick_b, frame_start_b, line_start_b, hsync_b, vsync_b, de_b;
    logic req_valid_c, pix_tick_c, frame_start_c, line_start_c, hsync_c, vsync_c, de_c;
    logic [11:0] rgb_a = 12'h0, rgb_b = 12'h0, rgb_c = 12'h0;
    logic [3:0] red_a, green_a, blue_a, red_b, green_b, blue_b, red_c, green_c, blue_c;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    vga_timing_pipe #(.H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(A_D), .PIPE(A_P), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .req_x(req_x_a), .req_y(req_y_a), .req_valid(req_valid_a),
        .pix_tick(pix_tick_a), .frame_start(frame_start_a), .line_start(line_start_a),
        .rgb_in(rgb_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
        .red(red_a), .green(green_a), .blue(blue_a));

    vga_timing_pipe #(.H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(B_D), .PIPE(B_P), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .req_x(req_x_b), .req_y(req_y_b), .req_valid(req_valid_b),
        .pix_tick(pix_tick_b), .frame_start(frame_start_b), .line_start(line_start_b),
        .rgb_in(rgb_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
        .red(red_b), .green(green_b), .blue(blue_b));

    vga_timing_pipe #(.H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(C_D), .PIPE(C_P), .CNT_W(CW)) dut_c (
        .clk(clk), .rst(rst), .req_x(req_x_c), .req_y(req_y_c), .req_valid(req_valid_c),
        .pix_tick(pix_tick_c), .frame_start(frame_start_c), .line_start(line_start_c),
        .rgb_in(rgb_c), .hsync(hsync_c), .vsync(vsync_c), .de(de_c),
        .red(red_c), .green(green_c), .blue(blue_c));

    function automatic logic [11:0] colour(int px, int ht, int vt);
        int h;
        int v;
        h = px % ht;
        v = (px / ht) % vt;
        return {h[3:0], v[3:0], 4'hA};
    endfunction

    // Expected {hsync, vsync, de, rgb} after e clk edges since reset release.
    function automatic logic [14:0] exp_out(int e, int d, int p, int ha, int hf, int hs, int hb,
                                            int va, int vf, int vs, int vb, bit hp, bit vp, bit white);
        int ht, vt, px, h, v;
        logic hsy, vsy, vis;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        px = e / d - 1 - p;
        if (px < 0) return {~hp, ~vp, 1'b0, 12'h000};
        h   = px % ht;
        v   = (px / ht) % vt;
        hsy = (h >= ha + hf) && (h < ha + hf + hs);
        vsy = (v >= va + vf) && (v < va + vf + vs);
        vis = (h < ha) && (v < va);
        return {hsy ? hp : ~hp, vsy ? vp : ~vp, vis,
                vis ? (white ? 12'hFFF : colour(px, ht, vt)) : 12'h000};
    endfunction

    // Expected {req_x, req_y, req_valid, pix_tick, line_start, frame_start}.
    function automatic logic [25:0] exp_req(int e, int d, int ht, int vt, int ha, int va);
        int t, h, v;
        logic tick, ls;
        t    = e / d;
        h    = t % ht;
        v    = (t / ht) % vt;
        tick = ((e + 1) % d == 0);
        ls   = tick && (h == 0);
        return {h[CW-1:0], v[CW-1:0], (h < ha) && (v < va), tick, ls, ls && (v == 0)};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (edge %0d)", name, ecnt);
    endtask

    task automatic drive_rgb();
        int e1;
        e1 = ecnt + 1;
        rgb_a = 12'h5C3;
        rgb_c = 12'h5C3;
        if (e1 % A_D == 0 && e1 / A_D - 1 - A_P >= 0)
            rgb_a = colour(e1 / A_D - 1 - A_P, A_HT, A_VT);
        if (e1 % C_D == 0 && e1 / C_D - 1 - C_P >= 0)
            rgb_c = colour(e1 / C_D - 1 - C_P, 14, 7);
        rgb_b = 12'hFFF;
    endtask

    // Advance one clk, check every DUT output against the model, then set up inputs.
    task automatic step();
        @(negedge clk);
        if (!rst) begin
            cmp("a_out", 32'({hsync_a, vsync_a, de_a, red_a, green_a, blue_a}),
                32'(exp_out(ecnt, A_D, A_P, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0, 1'b0, 1'b0)));
            cmp("a_req", 32'({req_x_a, req_y_a, req_valid_a, pix_tick_a, line_start_a, frame_start_a}),
                32'(exp_req(ecnt, A_D, A_HT, A_VT, A_HA, A_VA)));
            cmp("b_out", 32'({hsync_b, vsync_b, de_b, red_b, green_b, blue_b}),
                32'(exp_out(ecnt, B_D, B_P, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1, 1'b1, 1'b1)));
            cmp("b_req", 32'({req_x_b, req_y_b, req_valid_b, pix_tick_b, line_start_b, frame_start_b}),
                32'(exp_req(ecnt, B_D, 14, 7, B_HA, B_VA)));
            cmp("c_out", 32'({hsync_c, vsync_c, de_c, red_c, green_c, blue_c}),
                32'(exp_out(ecnt, C_D, C_P, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b0, 1'b0, 1'b0)));
            cmp("c_req", 32'({req_x_c, req_y_c, req_valid_c, pix_tick_c, line_start_c, frame_start_c}),
                32'(exp_req(ecnt, C_D, 14, 7, B_HA, B_VA)));
        end
        drive_rgb();
    endtask

    // Count consecutive clks a signal spends at 'lvl', starting from its next entry.
    task automatic run_len(input int which, input logic lvl, output int n, output bit ok);
        logic cur, prev;
        int   guard;
        ok = 1'b0;
        n  = 0;
        prev = lvl;
        for (guard = 0; guard < 2000; guard++) begin
            step();
            case (which)
                0: cur = hsync_a;
                1: cur = vsync_a;
                2: cur = hsync_b;
                default: cur = de_b;
            endcase
            if (cur == lvl && prev != lvl) begin
                ok = 1'b1;
                break;
            end
            prev = cur;
        end
        if (!ok) return;
        ok = 1'b0;
        for (guard = 0; guard < 2000; guard++) begin
            n++;
            step();
            case (which)
                0: cur = hsync_a;
                1: cur = vsync_a;
                2: cur = hsync_b;
                default: cur = de_b;
            endcase
            if (cur != lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Clks from one frame_start pulse to the next on instance A (0) or B (1).
    task automatic frame_period(input int which, output int n, output bit ok);
        int guard;
        ok = 1'b0;
        n  = 0;
        for (guard = 0; guard < 2000; guard++) begin
            if ((which == 0) ? frame_start_a : frame_start_b) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) return;
        ok = 1'b0;
        for (guard = 0; guard < 2000; guard++) begin
            step();
            n++;
            if ((which == 0) ? frame_start_a : frame_start_b) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pixel ticks from frame_start (inclusive) until de is first seen high.
    task automatic de_latency(input int which, output int n, output bit ok);
        int guard;
        ok = 1'b0;
        n  = 0;
        for (guard = 0; guard < 2000; guard++) begin
            step();
            if ((which == 0) ? frame_start_b : frame_start_c) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        ok = 1'b0;
        for (guard = 0; guard < 100; guard++) begin
            if ((which == 0) ? pix_tick_b : pix_tick_c) n++;
            step();
            if ((which == 0) ? de_b : de_c) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    vec_t tbl [12];

    initial begin
        int  n;
        int  op;
        int  t;
        bit  ok;

        tbl[0]  = '{0,  0, 1'b1, 1'b1, 1'b1, 12'h00A};
        tbl[1]  = '{7,  0, 1'b1, 1'b1, 1'b1, 12'h70A};
        tbl[2]  = '{8,  0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[3]  = '{10, 0, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[4]  = '{12, 0, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[5]  = '{13, 0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[6]  = '{5,  3, 1'b1, 1'b1, 1'b1, 12'h53A};
        tbl[7]  = '{14, 3, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[8]  = '{3,  4, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[9]  = '{3,  5, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[10] = '{11, 6, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[11] = '{0,  7, 1'b1, 1'b1, 1'b0, 12'h000};

        // Reset state while held.
        repeat (3) step();
        cmp("rst_a", 32'({hsync_a, vsync_a, de_a, red_a, green_a, blue_a, req_x_a, req_y_a}), 32'h0 | (32'b11 << 35-3-22+22) );
        cmp("rst_b", 32'({hsync_b, vsync_b, de_b, red_b, green_b, blue_b}), 32'h0);
        #2 rst = 1'b0;

        // Probe table on instance A, in raster order of output-aligned pixels.
        for (int i = 0; i < 12; i++) begin
            ok = 1'b0;
            for (int g = 0; g < 800; g++) begin
                step();
                op = ecnt / A_D - 1 - A_P;
                if (op >= 0 && op % A_HT == tbl[i].x && (op / A_HT) % A_VT == tbl[i].y) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) fail_timeout($sformatf("probe_%0d", i));
            else cmp($sformatf("probe(%0d,%0d)", tbl[i].x, tbl[i].y),
                     32'({hsync_a, vsync_a, de_a, red_a, green_a, blue_a}),
                     32'({tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].rgb}));
        end

        run_len(0, 1'b0, n, ok);
        if (!ok) fail_timeout("a_hsync_width"); else cmp("a_hsync_width", 32'(n), 32'd9);
        run_len(1, 1'b0, n, ok);
        if (!ok) fail_timeout("a_vsync_width"); else cmp("a_vsync_width", 32'(n), 32'd90);
        frame_period(0, n, ok);
        if (!ok) fail_timeout("a_frame_period"); else cmp("a_frame_period", 32'(n), 32'd360);
        frame_period(1, n, ok);
        if (!ok) fail_timeout("b_frame_period"); else cmp("b_frame_period", 32'(n), 32'd98);
        run_len(2, 1'b1, n, ok);
        if (!ok) fail_timeout("b_hsync_width"); else cmp("b_hsync_width", 32'(n), 32'd2);
        run_len(3, 1'b1, n, ok);
        if (!ok) fail_timeout("b_de_per_line"); else cmp("b_de_per_line", 32'(n), 32'd8);
        de_latency(0, n, ok);
        if (!ok) fail_timeout("b_de_latency"); else cmp("b_de_latency", 32'(n), 32'(B_P + 1));
        de_latency(1, n, ok);
        if (!ok) fail_timeout("c_de_latency"); else cmp("c_de_latency", 32'(n), 32'(C_P + 1));

        // Mid-frame reset on A while visible pixels are on the outputs.
        ok = 1'b0;
        for (int g = 0; g < 800; g++) begin
            step();
            t = ecnt / A_D;
            if (t % A_HT == 6 && (t / A_HT) % A_VT == 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout("midframe_wait");
        cmp("pre_rst_de_a", 32'(de_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        cmp("async_rst_a", 32'({hsync_a, vsync_a, de_a, red_a, green_a, blue_a, req_x_a}),
            32'({1'b1, 1'b1, 1'b0, 12'h000, 11'd0}));
        cmp("async_rst_b", 32'({hsync_b, vsync_b, de_b, red_b, green_b, blue_b}), 32'h0);
        repeat (2) step();
        #2 rst = 1'b0;
        n = 0;
        ok = 1'b0;
        for (int g = 0; g < 10; g++) begin
            step();
            n++;
            if (frame_start_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout("a_first_frame_start"); else cmp("a_first_frame_start", 32'(n), 32'd2);
        frame_period(0, n, ok);
        if (!ok) fail_timeout("a_frame_period_after_rst"); else cmp("a_frame_period_after_rst", 32'(n), 32'd360);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
